cpu_control_fsm: RTL and testbench

- Multi-cycle sequencer for the ARM-style core. It drives write_ir and write_pc into the instruction fetch stage.
- Samples the fetch stage's condition-qualified W_IR_valid and decodes IR.
- Issues one-cycle control strobes to the ALU, the NZCV flag register, data memory and the register file.
- Sits between the fetch stage and the execute datapath; it is the only source of the fetch control strobes.

---
 rtl/cpu_control_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
//
// Multi-cycle control sequencer for the ARM-style core. It is the only source
// of the fetch strobes (write_ir / write_pc), it classifies the instruction
// held in IR, and it issues one-cycle control strobes to the ALU, the NZCV
// flag register, data memory and the register file.
//
// Optional build macro:
//   CPU_CTRL_MEM_READY_EN - adds the mem_ready input. MEM then holds (with
//                           mem_rd/mem_wr held high) until mem_ready=1.
//                           Without it, MEM always lasts exactly one cycle.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter (wraps)
//
// Ports:
//   clk          system clock, FSM updates on posedge
//   rst          synchronous, active-high reset
//   run          level enable, 0 parks in IDLE at the next instruction boundary
//   IR           current instruction from the fetch stage
//   W_IR_valid   fetch stage: IR loaded and its condition passed
//   mem_ready    (optional) data memory has completed the access
//   write_ir     fetch strobe
//   write_pc     PC+4 strobe
//   alu_op       IR[24:21] in EXEC/MEM/WB, else 0
//   alu_src_imm  IR[25] in EXEC/MEM/WB, else 0
//   write_nzcv   flag register write strobe
//   mem_rd       data memory read strobe
//   mem_wr       data memory write strobe
//   write_reg    register file write strobe
//   reg_src_mem  writeback select, 1 = memory data, 0 = ALU result
//   undef        sticky undefined-instruction flag
//   state        current state encoding (debug)
//   retired      count of executed (condition-passed) instructions
// ---------------------------------------------------------------------------
module cpu_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      IR,
  input  logic             W_IR_valid,
`ifdef CPU_CTRL_MEM_READY_EN
  input  logic             mem_ready,
`endif
  output logic             write_ir,
  output logic             write_pc,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic             write_nzcv,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             write_reg,
  output logic             reg_src_mem,
  output logic             undef,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic             undef_q, undef_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Instruction field decode. Only classes 00 and 01 ever reach EXEC, so
  // IR[26] alone separates load/store from data processing there.
  logic       isLoadStore;
  logic       isCompare;
  logic       lBit;
  logic       memDone;
  logic       retireEn;
  state_e     boundaryState;
  logic       unusedIr;

  assign isLoadStore = IR[26];
  assign isCompare   = ~IR[26] & (IR[24:23] == 2'b10);
  assign lBit        = IR[20];
  assign unusedIr    = ^{IR[31:28], IR[19:0]};

`ifdef CPU_CTRL_MEM_READY_EN
  assign memDone = mem_ready;
`else
  assign memDone = 1'b1;
`endif

  // Where an instruction goes when it finishes (or is skipped): keep
  // fetching while run is high, otherwise park in IDLE.
  assign boundaryState = run ? S_FETCH : S_IDLE;

  // Next-state and Moore strobe decode. Every strobe is a function of the
  // registered state and IR only, so nothing can glitch high in a state
  // that does not own it. An instruction retires on the edge that leaves
  // its last active state (EXEC for compares, MEM for stores, WB otherwise).
  always_comb begin
    state_d     = state_q;
    undef_d     = undef_q;
    retireEn    = 1'b0;
    write_ir    = 1'b0;
    write_pc    = 1'b0;
    alu_op      = 4'd0;
    alu_src_imm = 1'b0;
    write_nzcv  = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    write_reg   = 1'b0;
    reg_src_mem = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        write_ir = 1'b1;
        write_pc = 1'b1;
        // A failed condition still advances the PC; the instruction is
        // simply skipped and does not count as retired.
        if (W_IR_valid) state_d = S_DECODE;
        else            state_d = boundaryState;
      end

      S_DECODE: begin
        if (IR[27]) begin
          state_d = S_HALT;
          undef_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_op      = IR[24:21];
        alu_src_imm = IR[25];
        if (isLoadStore) begin
          state_d = S_MEM;
        end else if (isCompare) begin
          // Compares exist only to set flags and never write back.
          write_nzcv = 1'b1;
          retireEn   = 1'b1;
          state_d    = boundaryState;
        end else begin
          write_nzcv = lBit;
          state_d    = S_WB;
        end
      end

      S_MEM: begin
        alu_op      = IR[24:21];
        alu_src_imm = IR[25];
        mem_rd      = lBit;
        mem_wr      = ~lBit;
        if (memDone) begin
          if (lBit) begin
            state_d = S_WB;
          end else begin
            retireEn = 1'b1;
            state_d  = boundaryState;
          end
        end
      end

      S_WB: begin
        alu_op      = IR[24:21];
        alu_src_imm = IR[25];
        write_reg   = 1'b1;
        reg_src_mem = isLoadStore;
        retireEn    = 1'b1;
        state_d     = boundaryState;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retired-instruction counter, wrapping naturally at 2^CNT_W.
  always_comb begin
    retired_d = retired_q;
    if (retireEn) retired_d = retired_q + 1'b1;
  end

  // State, sticky undef flag and retired counter. Reset is synchronous, so
  // a reset asserted mid-instruction lands on the next edge and the Moore
  // strobes drop to 0 from that edge with no partial writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      undef_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      undef_q   <= undef_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign undef   = undef_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_fsm
//
// Drives the sequencer the way the fetch stage would (IR / W_IR_valid change
// on the negedge of the FETCH cycle) and compares every cycle's outputs
// against a per-instruction cycle plan derived from the instruction class
// rules. Build with +define+CPU_CTRL_MEM_READY_EN to exercise memory waits.
// ---------------------------------------------------------------------------
module tb_cpu_control_fsm;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic [31:0]      IR;
  logic             W_IR_valid;
`ifdef CPU_CTRL_MEM_READY_EN
  logic             mem_ready;
`endif
  logic             write_ir;
  logic             write_pc;
  logic [3:0]       alu_op;
  logic             alu_src_imm;
  logic             write_nzcv;
  logic             mem_rd;
  logic             mem_wr;
  logic             write_reg;
  logic             reg_src_mem;
  logic             undef;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  int vectors     = 0;
  int miscompares = 0;
  int expRetired  = 0;

  typedef logic [15:0] vec_t;
  vec_t planQ[$];

  cpu_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .IR          (IR),
    .W_IR_valid  (W_IR_valid),
`ifdef CPU_CTRL_MEM_READY_EN
    .mem_ready   (mem_ready),
`endif
    .write_ir    (write_ir),
    .write_pc    (write_pc),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .write_nzcv  (write_nzcv),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .write_reg   (write_reg),
    .reg_src_mem (reg_src_mem),
    .undef       (undef),
    .state       (state),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends even if something wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Packs one cycle's expected outputs:
  // {state, write_ir, write_pc, alu_op, imm, nzcv, rd, wr, wreg, srcmem, undef}
  function automatic vec_t mk(input int st, input bit wir, input bit wpc,
                              input logic [3:0] op, input bit imm, input bit nz,
                              input bit rd, input bit wr, input bit wreg,
                              input bit src, input bit und);
    return {3'(st), wir, wpc, op, imm, nz, rd, wr, wreg, src, und};
  endfunction

  // reg_src_mem only means something while write_reg is high.
  function automatic vec_t observe();
    return {state, write_ir, write_pc, alu_op, alu_src_imm, write_nzcv,
            mem_rd, mem_wr, write_reg, reg_src_mem & write_reg, undef};
  endfunction

  // Expands one instruction into its expected cycle sequence.
  function automatic void planInstr(input logic [31:0] ir, input bit valid, input int memWait);
    logic [3:0] op;
    bit imm, load, cmp;
    op   = ir[24:21];
    imm  = ir[25];
    load = ir[20];
    cmp  = (ir[24:23] == 2'b10);
    planQ.delete();
    planQ.push_back(mk(1, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    if (!valid) return;
    planQ.push_back(mk(2, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    if (ir[27:26] == 2'b00) begin
      planQ.push_back(mk(3, 0, 0, op, imm, cmp ? 1'b1 : load, 0, 0, 0, 0, 0));
      if (!cmp) planQ.push_back(mk(5, 0, 0, op, imm, 0, 0, 0, 1, 0, 0));
    end else begin
      planQ.push_back(mk(3, 0, 0, op, imm, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k <= memWait; k++)
        planQ.push_back(mk(4, 0, 0, op, imm, 0, load, !load, 0, 0, 0));
      if (load) planQ.push_back(mk(5, 0, 0, op, imm, 0, 0, 0, 1, 1, 0));
    end
  endfunction

  // Runs one instruction starting at #1 after the posedge that entered
  // FETCH; returns at #1 after the posedge that enters the next FETCH.
  task automatic applyStimulus(input string name, input logic [31:0] ir, input bit valid,
                               input bit runAfter, input int memWait);
    int memSeen;
    memSeen = 0;
    planInstr(ir, valid, memWait);
    foreach (planQ[i]) begin
      checkOutput($sformatf("%s cyc%0d", name, i), 32'(observe()), 32'(planQ[i]));
      if (i == 0)
        checkOutput($sformatf("%s retired", name), 32'(retired), 32'(expRetired[CNT_W-1:0]));
      @(negedge clk);
      if (i == 0) begin
        IR         = ir;
        W_IR_valid = valid;
        run        = runAfter;
      end
`ifdef CPU_CTRL_MEM_READY_EN
      if (planQ[i][15:13] == 3'd4) begin
        mem_ready = (memSeen >= memWait);
        memSeen++;
      end else begin
        mem_ready = 1'b1;
      end
`endif
      @(posedge clk); #1;
    end
    if (valid) expRetired++;
    if (!runAfter) begin
      checkOutput($sformatf("%s park", name), 32'(observe()), 32'(mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
      run = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] ir;
    bit          valid, runAfter;
    int          memWait;

    rst        = 1'b1;
    run        = 1'b0;
    IR         = 32'd0;
    W_IR_valid = 1'b0;
`ifdef CPU_CTRL_MEM_READY_EN
    mem_ready  = 1'b1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset vec", 32'(observe()), 32'(mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)));
    checkOutput("reset retired", 32'(retired), 32'd0);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk); #1;

    // Directed class walk-through.
    applyStimulus("ADD", 32'hE0800000, 1'b1, 1'b1, 0);
    applyStimulus("CMP", 32'hE1500000, 1'b1, 1'b1, 0);
    applyStimulus("LDR", 32'hE4100000, 1'b1, 1'b1, 0);
    applyStimulus("STR", 32'hE4000000, 1'b1, 1'b1, 0);
    for (int s = 0; s < 3; s++)
      applyStimulus("SKIP", 32'hE0800000, 1'b0, 1'b1, 0);
    applyStimulus("ADD2", 32'hE0800000, 1'b1, 1'b1, 0);
`ifdef CPU_CTRL_MEM_READY_EN
    applyStimulus("LDRWAIT", 32'hE4100000, 1'b1, 1'b1, 3);
`endif

    // Randomized data-processing and load/store traffic.
    for (int n = 0; n < 150; n++) begin
      ir       = {4'hE, 1'b0, 1'($urandom_range(0, 1)), 26'($urandom)};
      valid    = ($urandom_range(0, 3) != 0);
      runAfter = ($urandom_range(0, 7) != 0);
      memWait  = 0;
`ifdef CPU_CTRL_MEM_READY_EN
      memWait  = $urandom_range(0, 2);
`endif
      applyStimulus($sformatf("RND%0d", n), ir, valid, runAfter, memWait);
    end

    // Reset mid-instruction (during EXEC of an ADD): no writeback follows.
    @(negedge clk);
    IR = 32'hE0800000; W_IR_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst exec", 32'(state), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    expRetired = 0;
    checkOutput("midrst vec", 32'(observe()), 32'(mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)));
    checkOutput("midrst retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef CPU_CTRL_MEM_READY_EN
    // Reset while MEM is holding for mem_ready.
    @(negedge clk);
    IR = 32'hE4100000; W_IR_valid = 1'b1; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("holdrst mem", 32'(observe()), 32'(mk(4, 0, 0, 4'd0, 0, 0, 1, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("holdrst vec", 32'(observe()), 32'(mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
`endif

    // Undefined class: DECODE then HALT, immune to run until reset.
    checkOutput("halt fetch", 32'(observe()), 32'(mk(1, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    IR = 32'hEA000000; W_IR_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("halt decode", 32'(observe()), 32'(mk(2, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checkOutput($sformatf("halt cyc%0d", c), 32'(observe()), 32'(mk(6, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1)));
    end
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    checkOutput("halt reset", 32'(observe()), 32'(mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)));
    checkOutput("halt reset retired", 32'(retired), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
